siso_tx_scheduler: RTL

- Shares one serial-out shift path among N_REQ parallel-word requesters.
- Round-robin arbitrates, loads the winner's word, and shifts it out one bit per enabled cycle in the requester's chosen direction.
- Flags transfer activity and inserts a programmable inter-frame gap.
- Sits between word-producing blocks and a single serial transmit line.

---
 rtl/siso_tx_scheduler_if.sv | 26 ++
 rtl/siso_tx_scheduler.sv | 76 +++++++
 2 files changed

// File: rtl/siso_tx_scheduler_if.sv
// siso_tx_scheduler_if: requester words in, serial frame and status out
interface siso_tx_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*WIDTH-1:0]   req_data;
  logic [N_REQ-1:0]         req_dir;
  logic                     shift_en;
  logic                     ser_out;
  logic                     ser_valid;
  logic                     ser_sof;
  logic                     ser_eof;
  logic                     busy;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic [N_REQ-1:0]         done;
  modport master (
    output req_valid, req_data, req_dir, shift_en,
    input  req_ready, ser_out, ser_valid, ser_sof, ser_eof, busy, grant_id, done
  );
  modport slave (
    input  req_valid, req_data, req_dir, shift_en,
    output req_ready, ser_out, ser_valid, ser_sof, ser_eof, busy, grant_id, done
  );
endinterface

// File: rtl/siso_tx_scheduler.sv
// siso_tx_scheduler: round-robin shares one serial shifter among parallel-word requesters
module siso_tx_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int GAP   = 2
) (
  input logic             clk,
  input logic             rst,
  siso_tx_scheduler_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GLAST = GW'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP_WAIT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gcnt;
  logic [IW-1:0]    ptr, gid, win;
  logic             dir, any, fire, sv, last, eof;
  // later loop iterations win, so the search from ptr+1 ends with highest priority
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--)
      if (bus.req_valid[(int'(ptr) + k) % N_REQ]) begin
        win = IW'((int'(ptr) + k) % N_REQ);
        any = 1'b1;
      end
  end
  assign fire = state == IDLE && any && rst;
  assign sv   = state == SHIFT && bus.shift_en;
  assign last = cnt == CW'(WIDTH - 1);
  assign eof  = sv && last;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = fire ? SHIFT : IDLE;
      SHIFT:    state_nx = eof ? (GAP > 0 ? GAP_WAIT : IDLE) : SHIFT;
      GAP_WAIT: state_nx = gcnt == GLAST ? IDLE : GAP_WAIT;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      gcnt  <= '0;
      dir   <= 1'b0;
      gid   <= '0;
      ptr   <= IW'(N_REQ - 1);
    end else begin
      state <= state_nx;
      gcnt  <= state == GAP_WAIT ? gcnt + 1'b1 : '0;
      if (fire) begin
        shreg <= bus.req_data[win*WIDTH +: WIDTH];
        dir   <= bus.req_dir[win];
        gid   <= win;
        ptr   <= win;
        cnt   <= '0;
      end else if (sv) begin
        shreg <= dir ? shreg << 1 : shreg >> 1;
        cnt   <= last ? '0 : cnt + 1'b1;
      end
    end
  assign bus.req_ready = fire ? N_REQ'(1) << win : '0;
  assign bus.ser_valid = sv;
  assign bus.ser_out   = sv && (dir ? shreg[WIDTH-1] : shreg[0]);
  assign bus.ser_sof   = sv && cnt == '0;
  assign bus.ser_eof   = eof;
  assign bus.busy      = state != IDLE;
  assign bus.grant_id  = gid;
  assign bus.done      = eof ? N_REQ'(1) << gid : '0;
endmodule
